clock_recovery: RTL and testbench

//  Receive-side counterpart of clock generation: samples an external IO clock, synchronises it to
//  clk_i and emits per-cycle rising/falling edge pulses plus the level. Measures the half-period in
//  clk_i cycles, qualifies it over consecutive half-periods and publishes locked half/quarter rate
//  (minus one) values. These feed the generator's recovery edges and rate programming.

---
 rtl/clock_recovery.sv | 181 ++++++++++++++++++
 tb/tb_clock_recovery.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_recovery.sv
// Recovers edge pulses, level and a qualified half-period rate from an asynchronous IO clock.
// state   | meaning
// IDLE    | recovery disabled, edges suppressed, counter held at 0
// ACQUIRE | waiting for the first edge to align the counter
// MEASURE | qualifying consecutive half-periods against a reference
// LOCKED  | rate outputs valid, tracking within tolerance
module clock_recovery #(
  parameter int COUNTER_WIDTH = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_COUNT    = 4,
  parameter int TOLERANCE     = 1
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     clk_en_i,
  input  logic                     recovery_en_i,
  input  logic                     io_clk_i,
  input  logic [COUNTER_WIDTH-1:0] idle_timeout_minus_one_i,
  output logic                     clk_level_o,
  output logic                     rising_edge_o,
  output logic                     falling_edge_o,
  output logic [COUNTER_WIDTH-1:0] half_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0] quarter_rate_minus_one_o,
  output logic                     locked_o,
  output logic                     mismatch_o,
  output logic                     timeout_o
);

  localparam int CW = COUNTER_WIDTH;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] TOL       = CW'(TOLERANCE);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, MEASURE = 2'd2, LOCKED = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            sync_level, prev_level_q;
  logic [CW-1:0]   counter_q, ref_q, diff, half_up, quarter;
  logic [MW-1:0]   match_q;
  logic            edge_det, in_tol, timeout_hit;
  logic            ref_load, match_inc, match_set1, match_clr;
  logic            lock_set, lock_clr, mismatch_set, timeout_set;
  logic            rising_q, falling_q, locked_q, mismatch_q, timeout_q;
  logic [CW-1:0]   half_q, quarter_q;

  // Synchroniser runs every cycle regardless of clk_en_i.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) sync_q <= '0;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], io_clk_i};
  end

  assign sync_level  = sync_q[SYNC_STAGES-1];
  assign edge_det    = (sync_level != prev_level_q) && recovery_en_i && (state_q != IDLE);
  assign diff        = (counter_q >= ref_q) ? (counter_q - ref_q) : (ref_q - counter_q);
  assign in_tol      = (diff <= TOL);
  assign timeout_hit = ((state_q == MEASURE) || (state_q == LOCKED)) &&
                       (counter_q == idle_timeout_minus_one_i) && !edge_det;
  // (ref+1)>>1 rewritten so it cannot overflow CW bits.
  assign half_up     = (ref_q >> 1) + {{(CW-1){1'b0}}, ref_q[0]};
  assign quarter     = (half_up == '0) ? '0 : (half_up - CW'(1));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clk_en_i) begin
      if (!recovery_en_i) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE:    state_d = ACQUIRE;
          ACQUIRE: if (edge_det) state_d = MEASURE;
          MEASURE: begin
            if (edge_det) begin
              if (in_tol && (match_q == LOCK_LAST)) state_d = LOCKED;
            end else if (timeout_hit) begin
              state_d = ACQUIRE;
            end
          end
          LOCKED: begin
            if (edge_det) begin
              if (!in_tol) state_d = MEASURE;
            end else if (timeout_hit) begin
              state_d = ACQUIRE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    ref_load     = 1'b0;
    match_inc    = 1'b0;
    match_set1   = 1'b0;
    match_clr    = 1'b0;
    lock_set     = 1'b0;
    lock_clr     = 1'b0;
    mismatch_set = 1'b0;
    timeout_set  = 1'b0;
    if (clk_en_i) begin
      if (!recovery_en_i) begin
        match_clr = 1'b1;
        lock_clr  = 1'b1;
      end else if ((state_q == MEASURE) || (state_q == LOCKED)) begin
        if (edge_det) begin
          if (!in_tol) begin
            ref_load     = 1'b1;
            match_set1   = 1'b1;
            lock_clr     = 1'b1;
            mismatch_set = (state_q == LOCKED);
          end else if (state_q == MEASURE) begin
            match_inc = 1'b1;
            lock_set  = (match_q == LOCK_LAST);
          end
        end else if (timeout_hit) begin
          timeout_set = 1'b1;
          match_clr   = 1'b1;
          lock_clr    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      prev_level_q <= 1'b0;
      counter_q    <= '0;
      ref_q        <= '0;
      match_q      <= '0;
      rising_q     <= 1'b0;
      falling_q    <= 1'b0;
      mismatch_q   <= 1'b0;
      timeout_q    <= 1'b0;
      locked_q     <= 1'b0;
      half_q       <= '0;
      quarter_q    <= '0;
    end else begin
      rising_q   <= 1'b0;
      falling_q  <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
      if (clk_en_i) begin
        prev_level_q <= sync_level;
        rising_q     <= edge_det && sync_level;
        falling_q    <= edge_det && !sync_level;
        mismatch_q   <= mismatch_set;
        timeout_q    <= timeout_set;
        if ((state_q == IDLE) || !recovery_en_i || edge_det) counter_q <= '0;
        else if (counter_q != '1)                           counter_q <= counter_q + CW'(1);
        if (ref_load) ref_q <= counter_q;
        if (match_clr)       match_q <= '0;
        else if (match_set1) match_q <= MW'(1);
        else if (match_inc)  match_q <= match_q + MW'(1);
        // Rates publish only on lock; they survive unlock, timeout and disable.
        if (lock_set) begin
          locked_q  <= 1'b1;
          half_q    <= ref_q;
          quarter_q <= quarter;
        end else if (lock_clr) begin
          locked_q  <= 1'b0;
        end
      end
    end
  end

  assign clk_level_o              = prev_level_q;
  assign rising_edge_o            = rising_q;
  assign falling_edge_o           = falling_q;
  assign half_rate_minus_one_o    = half_q;
  assign quarter_rate_minus_one_o = quarter_q;
  assign locked_o                 = locked_q;
  assign mismatch_o               = mismatch_q;
  assign timeout_o                = timeout_q;

endmodule

// File: tb/tb_clock_recovery.sv
// Scoreboard bench for clock_recovery: expected pulses and lock events are queued when io_clk is driven.
module tb_clock_recovery;
  localparam int CW = 16;
  localparam int M_IDLE = 0, M_ACQ = 1, M_MEAS = 2, M_LOCK = 3;

  logic clk = 1'b0, arst_n = 1'b0, clk_en = 1'b1, recovery_en = 1'b0, io_clk = 1'b0;
  logic [CW-1:0] idle_timeout = 16'd63;
  logic clk_level, rising, falling, locked, mismatch, timeout;
  logic [CW-1:0] half, quarter;

  int vectors = 0, miscompares = 0, cyc = 0;
  int m_state = M_IDLE, m_ref = 0, m_match = 0, m_last = 0;
  bit mon_en = 0;
  logic locked_prev = 1'b0;

  typedef struct {int cyc; int half; int quarter;} lock_exp_t;
  int q_rise[$], q_fall[$], q_mis[$], q_to[$], q_unlock[$];
  lock_exp_t q_lock[$];

  clock_recovery dut (
    .clk_i(clk), .arst_n_i(arst_n), .clk_en_i(clk_en), .recovery_en_i(recovery_en),
    .io_clk_i(io_clk), .idle_timeout_minus_one_i(idle_timeout),
    .clk_level_o(clk_level), .rising_edge_o(rising), .falling_edge_o(falling),
    .half_rate_minus_one_o(half), .quarter_rate_minus_one_o(quarter),
    .locked_o(locked), .mismatch_o(mismatch), .timeout_o(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_quarter(input int r);
    int h;
    h = (r + 1) / 2;
    return (h == 0) ? 0 : h - 1;
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Toggle io_clk at a negedge; pulses are due SYNC_STAGES+1 = 3 cycles later.
  task automatic toggle_io(input int frozen);
    int c, cand;
    c = cyc;
    io_clk = ~io_clk;
    if (m_state != M_IDLE) begin
      if (io_clk) q_rise.push_back(c + 3);
      else        q_fall.push_back(c + 3);
      if (m_state == M_ACQ) begin
        m_state = M_MEAS;
      end else begin
        cand = c - m_last - 1 - frozen;
        if (m_state == M_MEAS) begin
          if (absdiff(cand, m_ref) <= 1) begin
            m_match++;
            if (m_match == 4) begin
              m_state = M_LOCK;
              q_lock.push_back('{c + 3, m_ref, exp_quarter(m_ref)});
            end
          end else begin
            m_ref = cand;
            m_match = 1;
          end
        end else if (absdiff(cand, m_ref) > 1) begin
          q_mis.push_back(c + 3);
          q_unlock.push_back(c + 3);
          m_ref = cand;
          m_match = 1;
          m_state = M_MEAS;
        end
      end
    end
    m_last = c;
  endtask

  always @(negedge clk) begin
    int e;
    lock_exp_t le;
    if (mon_en) begin
      if (rising) begin
        vectors++;
        if (q_rise.size() == 0) begin miscompares++; $display("FAIL rise_unexpected: pulse at cycle %0d, none expected", cyc); end
        else begin e = q_rise.pop_front(); if (e != cyc) begin miscompares++; $display("FAIL rise_cycle: got %0d expected %0d", cyc, e); end end
      end else if (q_rise.size() > 0 && q_rise[0] < cyc) begin
        vectors++; miscompares++; e = q_rise.pop_front();
        $display("FAIL rise_missing: pulse absent, expected at cycle %0d", e);
      end
      if (falling) begin
        vectors++;
        if (q_fall.size() == 0) begin miscompares++; $display("FAIL fall_unexpected: pulse at cycle %0d, none expected", cyc); end
        else begin e = q_fall.pop_front(); if (e != cyc) begin miscompares++; $display("FAIL fall_cycle: got %0d expected %0d", cyc, e); end end
      end else if (q_fall.size() > 0 && q_fall[0] < cyc) begin
        vectors++; miscompares++; e = q_fall.pop_front();
        $display("FAIL fall_missing: pulse absent, expected at cycle %0d", e);
      end
      if (mismatch) begin
        vectors++;
        if (q_mis.size() == 0) begin miscompares++; $display("FAIL mismatch_unexpected: pulse at cycle %0d, none expected", cyc); end
        else begin e = q_mis.pop_front(); if (e != cyc) begin miscompares++; $display("FAIL mismatch_cycle: got %0d expected %0d", cyc, e); end end
      end else if (q_mis.size() > 0 && q_mis[0] < cyc) begin
        vectors++; miscompares++; e = q_mis.pop_front();
        $display("FAIL mismatch_missing: pulse absent, expected at cycle %0d", e);
      end
      if (timeout) begin
        vectors++;
        if (q_to.size() == 0) begin miscompares++; $display("FAIL timeout_unexpected: pulse at cycle %0d, none expected", cyc); end
        else begin e = q_to.pop_front(); if (e != cyc) begin miscompares++; $display("FAIL timeout_cycle: got %0d expected %0d", cyc, e); end end
      end else if (q_to.size() > 0 && q_to[0] < cyc) begin
        vectors++; miscompares++; e = q_to.pop_front();
        $display("FAIL timeout_missing: pulse absent, expected at cycle %0d", e);
      end
      if (locked && !locked_prev) begin
        vectors++;
        if (q_lock.size() == 0) begin miscompares++; $display("FAIL lock_unexpected: locked rose at cycle %0d", cyc); end
        else begin
          le = q_lock.pop_front();
          if (le.cyc != cyc || int'(half) != le.half || int'(quarter) != le.quarter) begin
            miscompares++;
            $display("FAIL lock_event: got cyc=%0d half=%0d quarter=%0d expected cyc=%0d half=%0d quarter=%0d",
                     cyc, half, quarter, le.cyc, le.half, le.quarter);
          end
        end
      end else if (q_lock.size() > 0 && q_lock[0].cyc < cyc) begin
        vectors++; miscompares++; le = q_lock.pop_front();
        $display("FAIL lock_missing: locked not risen, expected at cycle %0d", le.cyc);
      end
      if (!locked && locked_prev) begin
        vectors++;
        if (q_unlock.size() == 0) begin miscompares++; $display("FAIL unlock_unexpected: locked fell at cycle %0d", cyc); end
        else begin e = q_unlock.pop_front(); if (e != cyc) begin miscompares++; $display("FAIL unlock_cycle: got %0d expected %0d", cyc, e); end end
      end else if (q_unlock.size() > 0 && q_unlock[0] < cyc) begin
        vectors++; miscompares++; e = q_unlock.pop_front();
        $display("FAIL unlock_missing: locked still high, expected fall at cycle %0d", e);
      end
    end
    locked_prev = locked;
  end

  task automatic test_reset();
    tick(2);
    vectors++; if (clk_level !== 1'b0) begin miscompares++; $display("FAIL reset_level: got %b expected 0", clk_level); end
    vectors++; if (rising !== 1'b0 || falling !== 1'b0) begin miscompares++; $display("FAIL reset_edges: got %b%b expected 00", rising, falling); end
    vectors++; if (half !== '0) begin miscompares++; $display("FAIL reset_half: got %0d expected 0", half); end
    vectors++; if (quarter !== '0) begin miscompares++; $display("FAIL reset_quarter: got %0d expected 0", quarter); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b expected 0", locked); end
    vectors++; if (mismatch !== 1'b0 || timeout !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got %b%b expected 00", mismatch, timeout); end
    arst_n = 1'b1;
    tick(2);
    locked_prev = locked;
    mon_en = 1;
  endtask

  task automatic test_lock();
    recovery_en = 1'b1;
    m_state = M_ACQ;
    tick(3);
    for (int i = 0; i < 7; i++) begin
      toggle_io(0);
      if (i == 0) begin
        tick(3);
        vectors++; if (clk_level !== io_clk) begin miscompares++; $display("FAIL level_lag: got %b expected %b", clk_level, io_clk); end
        tick(7);
      end else tick(10);
    end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_10: locked got %b expected 1", locked); end
    vectors++; if (half !== 16'd9 || quarter !== 16'd4) begin miscompares++; $display("FAIL lock_10_rates: got %0d/%0d expected 9/4", half, quarter); end
  endtask

  task automatic test_retarget();
    for (int i = 0; i < 6; i++) begin toggle_io(0); tick(6); end
    vectors++; if (locked !== 1'b1 || half !== 16'd5 || quarter !== 16'd2) begin
      miscompares++; $display("FAIL retarget: got locked=%b half=%0d quarter=%0d expected 1/5/2", locked, half, quarter);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 6; i++) begin toggle_io(0); tick(10); end
    q_to.push_back(m_last + 67);
    q_unlock.push_back(m_last + 67);
    m_state = M_ACQ;
    m_match = 0;
    tick(70);
    vectors++; if (locked !== 1'b0 || half !== 16'd9 || quarter !== 16'd4) begin
      miscompares++; $display("FAIL timeout_state: got locked=%b half=%0d quarter=%0d expected 0/9/4", locked, half, quarter);
    end
  endtask

  task automatic test_jitter();
    int sp[6] = '{10, 11, 10, 11, 10, 10};
    for (int i = 0; i < 6; i++) begin toggle_io(0); tick(sp[i]); end
    vectors++; if (locked !== 1'b1 || half !== 16'd9) begin
      miscompares++; $display("FAIL jitter_lock: got locked=%b half=%0d expected 1/9", locked, half);
    end
  endtask

  task automatic test_clk_en_gap();
    toggle_io(0);
    tick(4);
    clk_en = 1'b0;
    tick(5);
    clk_en = 1'b1;
    tick(6);
    toggle_io(5);
    tick(10);
    toggle_io(0);
    tick(10);
    vectors++; if (locked !== 1'b1 || half !== 16'd9) begin
      miscompares++; $display("FAIL clk_en_gap: got locked=%b half=%0d expected 1/9", locked, half);
    end
  endtask

  task automatic test_recovery_en();
    toggle_io(0);
    tick(5);
    recovery_en = 1'b0;
    q_unlock.push_back(cyc + 1);
    m_state = M_IDLE;
    m_match = 0;
    tick(5);
    for (int i = 0; i < 3; i++) begin toggle_io(0); tick(10); end
    vectors++; if (locked !== 1'b0 || half !== 16'd9) begin
      miscompares++; $display("FAIL disabled_state: got locked=%b half=%0d expected 0/9", locked, half);
    end
    recovery_en = 1'b1;
    m_state = M_ACQ;
    tick(5);
    for (int i = 0; i < 6; i++) begin toggle_io(0); tick(10); end
    vectors++; if (locked !== 1'b1 || half !== 16'd9 || quarter !== 16'd4) begin
      miscompares++; $display("FAIL reenable_lock: got locked=%b half=%0d quarter=%0d expected 1/9/4", locked, half, quarter);
    end
  endtask

  task automatic test_drain();
    vectors++; if (q_rise.size() + q_fall.size() !== 0) begin miscompares++; $display("FAIL drain_edges: %0d pending expected 0", q_rise.size() + q_fall.size()); end
    vectors++; if (q_mis.size() + q_to.size() !== 0) begin miscompares++; $display("FAIL drain_pulses: %0d pending expected 0", q_mis.size() + q_to.size()); end
    vectors++; if (q_lock.size() + q_unlock.size() !== 0) begin miscompares++; $display("FAIL drain_lock: %0d pending expected 0", q_lock.size() + q_unlock.size()); end
  endtask

  task automatic test_reset_mid();
    mon_en = 0;
    arst_n = 1'b0;
    #1;
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL midreset_locked: got %b expected 0", locked); end
    vectors++; if (half !== '0 || quarter !== '0) begin miscompares++; $display("FAIL midreset_rates: got %0d/%0d expected 0/0", half, quarter); end
    vectors++; if (clk_level !== 1'b0) begin miscompares++; $display("FAIL midreset_level: got %b expected 0", clk_level); end
    vectors++; if ({rising, falling, mismatch, timeout} !== 4'b0) begin
      miscompares++; $display("FAIL midreset_pulses: got %b expected 0000", {rising, falling, mismatch, timeout});
    end
    tick(2);
    arst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_retarget();
    test_timeout();
    test_jitter();
    test_clk_en_gap();
    test_recovery_en();
    test_drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
